module_register_file_scb: RTL
=============================

MODULE_REGISTER_FILE_SCB -- requirements
Module: module_register_file_scb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter REGS, default 32, register count (power of two, >=2); AW = $clog2(REGS).
REQ-003 SHALL have parameter RPORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port ra  input  RPORTS x AW  read addresses.
REQ-008 SHALL have port rd  output  RPORTS x XLEN  read data.
REQ-009 SHALL have port rbusy  output  RPORTS  scoreboard busy flag of each read address.
REQ-010 SHALL have ports wa/wd/we  input  AW/XLEN/1  writeback address, data, enable.
REQ-011 SHALL have ports iss_addr/iss_valid  input  AW/1  issue: mark destination register pending.
REQ-012 SHALL have port clr_req  input  1  request a full register clear.
REQ-013 SHALL have port ready  output  1  high when the file accepts writes/issues and returns valid reads.

Function
REQ-014 SHALL implement FSM states CLEAR and IDLE; CLEAR->IDLE when clear counter equals REGS-1; IDLE->CLEAR on clr_req.
REQ-015 In CLEAR, SHALL write zero to reg[cnt] each cycle, cnt incrementing 0..REGS-1 (one write per cycle, RAM-inferable); busy bits all zero.
REQ-016 ready SHALL equal (state==IDLE), registered; rd SHALL read all zeros and rbusy all zeros while ready=0.
REQ-017 In IDLE, reads SHALL be combinational: rd[i] = reg[ra[i]].
REQ-018 Write-through bypass: if we and wa==ra[i] (and not the zero register), rd[i] SHALL equal wd in the same cycle.
REQ-019 With ZERO_REG=1, address 0 SHALL read 0, writes to it SHALL be discarded, its busy bit SHALL never set.
REQ-020 Writes SHALL commit on the rising edge when we=1 and ready=1; we, iss_valid ignored when ready=0.
REQ-021 iss_valid SHALL set busy[iss_addr] at the edge; we SHALL clear busy[wa] at the edge.
REQ-022 Simultaneous iss_valid and we to the same address: busy SHALL end set (new issue wins); data written.
REQ-023 rbusy[i] = busy[ra[i]] with bypass: forced 0 when we and wa==ra[i] unless iss_valid and iss_addr==ra[i] same cycle.
REQ-024 clr_req while already in CLEAR SHALL restart cnt at 0; clr_req in IDLE with we pending SHALL drop the write.

Reset
REQ-025 rst_n=0 at an edge SHALL set state=CLEAR, cnt=0, busy=0, ready=0; register contents cleared by the CLEAR sweep.
REQ-026 ready SHALL rise exactly REGS cycles after the first edge with rst_n=1 (32 for defaults).
REQ-027 Reset asserted mid-CLEAR SHALL restart the sweep at cnt=0.

Structure
REQ-028 FSM state typedef (CLEAR, IDLE) and default parameter constants SHALL live in shared package regfile_pkg.
REQ-029 Busy tracking SHALL be sub-module module_scoreboard (REGS bits, set/clear ports, RPORTS lookup ports with bypass).
REQ-030 Storage SHALL be a single unpacked array with one write port to permit distributed-RAM inference.

Verification
REQ-031 Reset held 3 cycles, release -> ready=0 for 32 cycles, then 1; every rd reads 0x00000000.
REQ-032 IDLE, we=1 wa=1 wd=69, ra[0]=1 same cycle -> rd[0]=69 combinationally; next cycle we=0 -> rd[0]=69.
REQ-033 we=1 wa=0 wd=0xDEADBEEF -> ra[0]=0 reads 0 next cycle; iss_addr=0 -> rbusy stays 0.
REQ-034 iss_valid addr 5 -> rbusy for ra=5 is 1 next cycle; we wa=5 -> rbusy 0 same cycle; iss+we both addr 5 -> rbusy 1 after edge.
REQ-035 Write x7=0x1234, assert clr_req -> ready 0 for 32 cycles, then x7 reads 0, all busy 0.
REQ-036 Assert rst_n=0 at cnt=10 in CLEAR -> sweep restarts, ready rises 32 cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int XLEN_DEF     = 32;
  localparam int REGS_DEF     = 32;
  localparam int RPORTS_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;

endpackage

// File: rtl/module_register_file_scb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on writeback.
module module_scoreboard
  import regfile_pkg::*;
#(
  parameter int REGS     = REGS_DEF,
  parameter int RPORTS   = RPORTS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_all,
  input  logic                       set_en,
  input  logic [AW-1:0]              set_addr,
  input  logic                       clr_en,
  input  logic [AW-1:0]              clr_addr,
  input  logic [RPORTS-1:0][AW-1:0]  la,
  output logic [RPORTS-1:0]          lbusy
);

  logic [REGS-1:0] busy;
  logic            set_ok;

  assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

  // Set is applied after clear so a same-cycle re-issue leaves the bit pending.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_all) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_ok) busy[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    lbusy = '0;
    for (int i = 0; i < RPORTS; i++) begin
      if (clr_en && (clr_addr == la[i]) && !(set_ok && (set_addr == la[i])))
        lbusy[i] = 1'b0;
      else
        lbusy[i] = busy[la[i]];
    end
  end

endmodule

// File: rtl/module_register_file_scb.sv
// Multi-port register file with write-through bypass, busy scoreboard and a
// sequential clear sweep that runs after reset or on request.
//
//   state | meaning
//   CLEAR | sweeping zero into reg[cnt], one register per cycle; file not ready
//   IDLE  | normal operation: reads, writes and issues accepted
module module_register_file_scb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REGS     = REGS_DEF,
  parameter int RPORTS   = RPORTS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  localparam int AW      = $clog2(REGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [RPORTS-1:0][AW-1:0]   ra,
  output logic [RPORTS-1:0][XLEN-1:0] rd,
  output logic [RPORTS-1:0]           rbusy,
  input  logic [AW-1:0]               wa,
  input  logic [XLEN-1:0]             wd,
  input  logic                        we,
  input  logic [AW-1:0]               iss_addr,
  input  logic                        iss_valid,
  input  logic                        clr_req,
  output logic                        ready
);

  localparam logic [AW-1:0] LAST = AW'(REGS - 1);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] mem [REGS];

  logic            accept;
  logic            we_eff;
  logic            iss_eff;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic [RPORTS-1:0] sb_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_req) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ready <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A clear request in IDLE wins over any writeback or issue in the same cycle.
  assign accept  = ready && (state == IDLE) && !clr_req;
  assign we_eff  = we && accept && !((ZERO_REG != 0) && (wa == '0));
  assign iss_eff = iss_valid && accept;

  assign mem_we = rst_n && ((state == CLEAR) || we_eff);
  assign mem_wa = (state == CLEAR) ? cnt : wa;
  assign mem_wd = (state == CLEAR) ? '0 : wd;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < RPORTS; i++) begin
      if (!ready || ((ZERO_REG != 0) && (ra[i] == '0)))
        rd[i] = '0;
      else if (we_eff && (wa == ra[i]))
        rd[i] = wd;
      else
        rd[i] = mem[ra[i]];
    end
  end

  module_scoreboard #(
    .REGS     (REGS),
    .RPORTS   (RPORTS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_all  ((state == CLEAR) || clr_req),
    .set_en   (iss_eff),
    .set_addr (iss_addr),
    .clr_en   (we_eff),
    .clr_addr (wa),
    .la       (ra),
    .lbusy    (sb_busy)
  );

  assign rbusy = ready ? sb_busy : '0;

endmodule
